// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use, branch squash, memory wait, halt/drain/restart.
// Optional stall-cycle counter enabled by defining PIPELINE_CTRL_PERF_EN; otherwise stall_cycles reads 0.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memread_ex,
  input  logic [2:0]             regwrite_adr_ex,
  input  logic [2:0]             rs_adr_id,
  input  logic [2:0]             rt_adr_id,
  input  logic                   uses_rs_id,
  input  logic                   uses_rt_id,
  input  logic                   branch_taken_ex,
  input  logic                   halt_id,
  input  logic                   restart,
  input  logic                   mem_req_mem,
  input  logic                   mem_ack,
  output logic                   en_pc,
  output logic                   en_ifid,
  output logic                   en_idex,
  output logic                   en_exmem,
  output logic                   en_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   flush_exmem,
  output logic                   flush_memwb,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ret_drain_q, ret_drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_wait_c;
  logic               load_use_c;
  logic               drain_step_c;

  assign mem_wait_c = mem_req_mem && !mem_ack;
  assign load_use_c = memread_ex && (regwrite_adr_ex != 3'd0) &&
                      ((uses_rs_id && (rs_adr_id == regwrite_adr_ex)) ||
                       (uses_rt_id && (rt_adr_id == regwrite_adr_ex)));

  // Next state and enable/flush decode; the outputs act at the next clock edge
  always_comb begin
    en_pc        = 1'b1;
    en_ifid      = 1'b1;
    en_idex      = 1'b1;
    en_exmem     = 1'b1;
    en_memwb     = 1'b1;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_exmem  = 1'b0;
    flush_memwb  = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    ret_drain_d  = ret_drain_q;
    cnt_d        = cnt_q;
    drain_step_c = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        if (state_q == DRAIN) begin
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          flush_ifid = 1'b1;
        end
        if (mem_wait_c) begin
          en_pc       = 1'b0;
          en_ifid     = 1'b0;
          en_idex     = 1'b0;
          en_exmem    = 1'b0;
          en_memwb    = 1'b1;
          flush_ifid  = 1'b0;
          flush_memwb = 1'b1;
          state_d     = MEMWAIT;
          ret_drain_d = (state_q == DRAIN);
        end else if (branch_taken_ex) begin
          en_pc        = 1'b1;
          en_ifid      = 1'b1;
          flush_ifid   = 1'b1;
          flush_idex   = 1'b1;
          drain_step_c = (state_q == DRAIN);
        end else if ((state_q == RUN) && halt_id) begin
          en_pc      = 1'b0;
          flush_ifid = 1'b1;
          state_d    = DRAIN;
          cnt_d      = CNT_W'(DRAIN_CYCLES);
        end else if (load_use_c) begin
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          flush_idex = 1'b1;
        end else begin
          drain_step_c = (state_q == DRAIN);
        end
      end
      MEMWAIT: begin
        if (!mem_ack) begin
          en_pc       = 1'b0;
          en_ifid     = 1'b0;
          en_idex     = 1'b0;
          en_exmem    = 1'b0;
          en_memwb    = 1'b1;
          flush_memwb = 1'b1;
        end else begin
          // Ack cycle advances the whole pipe and counts as drain progress
          state_d      = ret_drain_q ? DRAIN : RUN;
          drain_step_c = ret_drain_q;
          ret_drain_d  = 1'b0;
        end
      end
      HALTED: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        en_exmem = 1'b0;
        en_memwb = 1'b0;
        halted   = 1'b1;
        if (restart) begin
          en_pc      = 1'b1;
          flush_ifid = 1'b1;
          halted     = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (drain_step_c) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = HALTED;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (!reset) begin
      en_pc       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      ret_drain_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles with the PC held outside HALTED
  always_comb begin
    stall_d = stall_q;
    if (!en_pc && (state_q != HALTED) && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        memread_ex;
  logic [2:0]  regwrite_adr_ex;
  logic [2:0]  rs_adr_id;
  logic [2:0]  rt_adr_id;
  logic        uses_rs_id;
  logic        uses_rt_id;
  logic        branch_taken_ex;
  logic        halt_id;
  logic        restart;
  logic        mem_req_mem;
  logic        mem_ack;
  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        halted;
  logic [15:0] stall_cycles;

  int n_tests;
  int n_fail;
  int exp_stall;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .memread_ex(memread_ex), .regwrite_adr_ex(regwrite_adr_ex),
    .rs_adr_id(rs_adr_id), .rt_adr_id(rt_adr_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .branch_taken_ex(branch_taken_ex), .halt_id(halt_id), .restart(restart),
    .mem_req_mem(mem_req_mem), .mem_ack(mem_ack),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       memread;
    logic [2:0] wr;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       hlt;
    logic       mreq;
    logic       mack;
    logic       rst_p;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [3:0] fl;   // {ifid, idex, exmem, memwb}
  } vec_t;

  vec_t vecs[11];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    memread_ex = 1'b0; regwrite_adr_ex = 3'd0; rs_adr_id = 3'd0; rt_adr_id = 3'd0;
    uses_rs_id = 1'b0; uses_rt_id = 1'b0; branch_taken_ex = 1'b0; halt_id = 1'b0;
    restart = 1'b0; mem_req_mem = 1'b0; mem_ack = 1'b0;
  endtask

  function automatic logic [15:0] stall_exp();
`ifdef PIPELINE_CTRL_PERF_EN
    return (exp_stall > 65535) ? 16'hFFFF : 16'(exp_stall);
`else
    return 16'h0000;
`endif
  endfunction

  // One cycle: check outputs at the falling edge, update the stall model, then pass the rising edge
  task automatic cyc(input string tag, input logic [4:0] en, input logic [3:0] fl, input logic h);
    @(negedge clk);
    cmp({tag, "_en"}, 32'({en_pc, en_ifid, en_idex, en_exmem, en_memwb}), 32'(en));
    cmp({tag, "_flush"}, 32'({flush_ifid, flush_idex, flush_exmem, flush_memwb}), 32'(fl));
    cmp({tag, "_halted"}, 32'(halted), 32'(h));
    cmp({tag, "_stall"}, 32'(stall_cycles), 32'(stall_exp()));
    if (!reset) exp_stall = 0;
    else if (!en[4] && !h) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_stall = 0;
    //            memrd wr    rs    rt    urs   urt   br    hlt   mreq  mack  rst   en        fl
    vecs[0]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000};
    vecs[1]  = '{1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100};
    vecs[2]  = '{1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000};
    vecs[3]  = '{1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100};
    vecs[4]  = '{1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000};
    vecs[5]  = '{1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000};
    vecs[6]  = '{1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b1100};
    vecs[7]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b1100};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 4'b0000};
    vecs[9]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 4'b0000};
    vecs[10] = '{1'b1, 3'd3, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000};

    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst0", 5'b00000, 4'b1111, 1'b0);
    cyc("rst1", 5'b00000, 4'b1111, 1'b0);
    reset = 1'b1;
    cyc("post_rst", 5'b11111, 4'b0000, 1'b0);

    for (int i = 0; i < 11; i++) begin
      memread_ex = vecs[i].memread; regwrite_adr_ex = vecs[i].wr;
      rs_adr_id = vecs[i].rs; rt_adr_id = vecs[i].rt;
      uses_rs_id = vecs[i].urs; uses_rt_id = vecs[i].urt;
      branch_taken_ex = vecs[i].br; halt_id = vecs[i].hlt;
      mem_req_mem = vecs[i].mreq; mem_ack = vecs[i].mack; restart = vecs[i].rst_p;
      cyc($sformatf("vec%0d", i), vecs[i].en, vecs[i].fl, 1'b0);
    end
    idle();
    cyc("after_vecs", 5'b11111, 4'b0000, 1'b0);

    // Four-cycle memory wait from RUN
    mem_req_mem = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("memwait%0d", i), 5'b00001, 4'b0001, 1'b0);
    mem_ack = 1'b1;
    cyc("mem_ack", 5'b11111, 4'b0000, 1'b0);
    idle();
    cyc("mem_done", 5'b11111, 4'b0000, 1'b0);

    // Halt with halt_id held during drain; halted four cycles after the halt cycle
    halt_id = 1'b1;
    cyc("halt", 5'b01111, 4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) cyc($sformatf("drain%0d", i), 5'b00111, 4'b1000, 1'b0);
    halt_id = 1'b0;
    cyc("halted0", 5'b00000, 4'b0000, 1'b1);
    cyc("halted1", 5'b00000, 4'b0000, 1'b1);
    restart = 1'b1;
    cyc("restart", 5'b10000, 4'b1000, 1'b0);
    restart = 1'b0;
    cyc("run_again", 5'b11111, 4'b0000, 1'b0);

    // Halt with a two-cycle memory wait inside drain
    halt_id = 1'b1;
    cyc("halt_mw", 5'b01111, 4'b1000, 1'b0);
    halt_id = 1'b0;
    mem_req_mem = 1'b1; mem_ack = 1'b0;
    cyc("drain_mw0", 5'b00001, 4'b0001, 1'b0);
    cyc("drain_mw1", 5'b00001, 4'b0001, 1'b0);
    mem_ack = 1'b1;
    cyc("drain_ack", 5'b11111, 4'b0000, 1'b0);
    idle();
    cyc("drain_mw_d0", 5'b00111, 4'b1000, 1'b0);
    cyc("drain_mw_d1", 5'b00111, 4'b1000, 1'b0);
    cyc("halted_mw", 5'b00000, 4'b0000, 1'b1);
    restart = 1'b1;
    cyc("restart_mw", 5'b10000, 4'b1000, 1'b0);
    restart = 1'b0;
    cyc("run_mw", 5'b11111, 4'b0000, 1'b0);

    // Reset in the middle of a memory wait returns to RUN with a cleared counter
    mem_req_mem = 1'b1; mem_ack = 1'b0;
    cyc("mw_pre_rst", 5'b00001, 4'b0001, 1'b0);
    reset = 1'b0;
    cyc("mw_rst", 5'b00000, 4'b1111, 1'b0);
    reset = 1'b1;
    idle();
    cyc("mw_rst_run", 5'b11111, 4'b0000, 1'b0);

    // Saturation: memory wait longer than the counter range
    mem_req_mem = 1'b1; mem_ack = 1'b0;
    repeat (65541) @(posedge clk);
    #1;
    exp_stall = exp_stall + 65541;
    cmp("stall_saturate", 32'(stall_cycles), 32'(stall_exp()));
    mem_ack = 1'b1;
    cyc("sat_ack", 5'b11111, 4'b0000, 1'b0);
    idle();
    cyc("sat_done", 5'b11111, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 16-bit core. It drives the enable and flush pairs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use stalls, taken-branch squashes, multi-cycle data-memory waits, and halt/drain/restart.
All enable/flush outputs are combinational from state and inputs, so they take effect at the next clock edge.

Parameters:
DRAIN_CYCLES, 3, cycles allowed after a halt enters ID before the core is declared halted (ID/EX, EX/MEM, MEM/WB drain)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-low reset (asserted when 0)
memread_ex  in  1  instruction in EX is a load
regwrite_adr_ex  in  3  destination register of the instruction in EX
rs_adr_id  in  3  first source register of the instruction in ID
rt_adr_id  in  3  second source register of the instruction in ID
uses_rs_id  in  1  ID instruction reads rs
uses_rt_id  in  1  ID instruction reads rt
branch_taken_ex  in  1  branch/jump in EX resolved taken; PC mux selects target
halt_id  in  1  HLT instruction is in ID
restart  in  1  single-cycle pulse that leaves HALTED
mem_req_mem  in  1  MEM-stage instruction accesses data memory
mem_ack  in  1  data memory completes the access this cycle
en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register load enables
flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  synchronous clear (bubble insert)
halted  out  1  core is halted
stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, MEMWAIT, DRAIN, HALTED. Reset (reset==0 at an edge) -> RUN, drain counter=0, stall_cycles=0. Reset mid-wait or mid-drain aborts to RUN.
- While reset==0: all en_*=0, all flush_*=1, halted=0.
- Default in RUN: all en_*=1, all flush_*=0.
- Priority in RUN and DRAIN, highest first:
  - (1) Memory wait, when mem_req_mem && !mem_ack: en_pc=en_ifid=en_idex=en_exmem=0; en_memwb=1, flush_memwb=1 (bubble into WB). Next state is MEMWAIT. The DRAIN return point is remembered.
  - (2) Branch, when branch_taken_ex: flush_ifid=1, flush_idex=1, all enables 1. This overrides halt_id and load-use in the same cycle.
  - (3) Halt, in RUN when halt_id: en_pc=0, flush_ifid=1. Next state is DRAIN with the counter loaded to DRAIN_CYCLES.
  - (4) Load-use, when memread_ex && regwrite_adr_ex!=0 && ((uses_rs_id && rs_adr_id==regwrite_adr_ex) || (uses_rt_id && rt_adr_id==regwrite_adr_ex)): en_pc=0, en_ifid=0, flush_idex=1. This is a one-cycle bubble. The hazard clears next cycle because the load has moved to MEM.
- mem_req_mem && mem_ack in the same cycle: no stall; single-cycle access.
- MEMWAIT: same outputs as (1) every cycle until mem_ack=1.
  - On the ack cycle, all en_*=1 and flush_*=0, so MEM/WB captures the data.
  - Next state is RUN, or DRAIN if entered from DRAIN.
  - Branch, halt and load-use inputs are ignored in MEMWAIT.
- DRAIN: en_pc=0, en_ifid=0, flush_ifid=1. The rest of the pipeline advances.
  - Counter decrements once per non-stalled cycle.
  - At 0 -> HALTED.
  - halt_id is ignored.
- HALTED: all en_*=0, flush_*=0, halted=1.
  - restart=1 -> RUN; that cycle en_pc=1 and flush_ifid=1.
  - restart is ignored in any other state.
- stall_cycles increments by 1 in each cycle where en_pc==0 and state!=HALTED and reset==1. It saturates at 2^STALL_CNT_W-1 and does not wrap.

Optional Feature:
PIPELINE_CTRL_PERF_EN
- Defined: stall_cycles is implemented as above.
- Undefined: the counter logic is removed and stall_cycles is tied to 0. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> all flush_*=1, all en_*=0, halted=0, stall_cycles=0; first cycle after release -> all en_*=1, all flush_*=0.
- Load-use: memread_ex=1, regwrite_adr_ex=3, uses_rs_id=1, rs_adr_id=3 for one cycle -> en_pc=0, en_ifid=0, flush_idex=1, stall_cycles 0->1. Repeat with regwrite_adr_ex=0 -> no stall.
- Branch vs load-use: branch_taken_ex=1 with the load-use condition true -> flush_ifid=1, flush_idex=1, en_pc=1, stall_cycles unchanged.
- Memory wait: mem_req_mem=1, mem_ack=0 for 4 cycles then ack -> 4 cycles with en_exmem=0, en_memwb=1, flush_memwb=1; ack cycle all enables 1; stall_cycles=4.
- Halt/drain/restart: halt_id=1 -> DRAIN, halted=1 exactly 4 cycles later (1 + DRAIN_CYCLES). restart pulse -> halted=0, en_pc=1, flush_ifid=1 that cycle.
- Halt with memory wait during drain: a 2-cycle mem wait inside DRAIN -> halted asserts 2 cycles later than with no wait. Saturation: force a 2^16+5 cycle mem wait -> stall_cycles=16'hFFFF.
